// File: rtl/k_and_s_pkg.sv
// rtl/k_and_s_pkg.sv - shared decode types for the K&S processor
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_HALT, I_LOAD, I_STORE,
    I_MOVE, I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV
  } decoded_instruction_type;

endpackage

// File: rtl/ks_control_unit.sv
// rtl/ks_control_unit.sv - multicycle fetch/decode/execute control FSM for the K&S datapath
// Optional KS_CTRL_PERF_CNT_EN adds instr_retired / cycle_count counters.
module ks_control_unit
  import k_and_s_pkg::*;
#(
  parameter int RAM_WAIT_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt
`ifdef KS_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]             instr_retired,
  output logic [15:0]             cycle_count
`endif
);

  localparam int CW = (RAM_WAIT_CYCLES > 0) ? $clog2(RAM_WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] W_MAX = CW'(RAM_WAIT_CYCLES);

  typedef enum logic [2:0] {
    FETCH, DECODE, LOAD_MEM, STORE_MEM, EXEC_ALU, BRANCH_EVAL, NEXT_PC, HALTED
  } state_t;

  state_t        state, nxt_state;
  logic [CW-1:0] wait_cnt, nxt_cnt;
  logic          wait_done, nxt_last, taken;
  logic [1:0]    alu_op;
  logic          branch_q, pc_q, ir_q, addr_q, c_q, wr_q, fl_q, ram_q, halt_q;
  logic [1:0]    op_q;

  // Signed overflow is carried for future branch types; no current branch tests it.
  logic unused_flags;
  assign unused_flags = signed_overflow;

  assign wait_done = (wait_cnt == W_MAX);

  always_comb begin
    taken  = 1'b0;
    alu_op = 2'b00;
    case (decoded_instruction)
      I_BRANCH: taken = 1'b1;
      I_BZERO:  taken = zero_op;
      I_BNZERO: taken = !zero_op;
      I_BNEG:   taken = neg_op;
      I_BNNEG:  taken = !neg_op;
      I_BOV:    taken = unsigned_overflow;
      I_BNOV:   taken = !unsigned_overflow;
      I_AND:    alu_op = 2'b01;
      I_OR:     alu_op = 2'b10;
      I_SUB:    alu_op = 2'b11;
      default:  ;
    endcase
  end

  always_comb begin
    nxt_state = state;
    case (state)
      FETCH:       if (wait_done) nxt_state = DECODE;
      DECODE: begin
        case (decoded_instruction)
          I_NOP:   nxt_state = NEXT_PC;
          I_HALT:  nxt_state = HALTED;
          I_LOAD:  nxt_state = LOAD_MEM;
          I_STORE: nxt_state = STORE_MEM;
          I_MOVE, I_ADD, I_SUB, I_AND, I_OR: nxt_state = EXEC_ALU;
          default: nxt_state = BRANCH_EVAL;
        endcase
      end
      LOAD_MEM,
      STORE_MEM:   if (wait_done) nxt_state = NEXT_PC;
      EXEC_ALU:    nxt_state = NEXT_PC;
      BRANCH_EVAL: nxt_state = branch_q ? FETCH : NEXT_PC;
      NEXT_PC:     nxt_state = FETCH;
      HALTED:      nxt_state = HALTED;
      default:     nxt_state = FETCH;
    endcase
    nxt_cnt  = (nxt_state != state) ? '0 : (wait_done ? wait_cnt : wait_cnt + 1'b1);
    nxt_last = (nxt_cnt == W_MAX);
  end

  // Outputs are registered for the state being entered, so they line up with that state's cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      branch_q <= 1'b0; pc_q  <= 1'b0; addr_q <= 1'b0; c_q    <= 1'b0;
      wr_q     <= 1'b0; fl_q  <= 1'b0; ram_q  <= 1'b0; halt_q <= 1'b0;
      op_q     <= 2'b00;
      ir_q     <= (RAM_WAIT_CYCLES == 0);
    end else begin
      state    <= nxt_state;
      wait_cnt <= nxt_cnt;
      branch_q <= 1'b0; pc_q  <= 1'b0; ir_q   <= 1'b0; addr_q <= 1'b0; c_q <= 1'b0;
      wr_q     <= 1'b0; fl_q  <= 1'b0; ram_q  <= 1'b0; halt_q <= 1'b0;
      op_q     <= 2'b00;
      case (nxt_state)
        FETCH:       ir_q <= nxt_last;
        LOAD_MEM:    begin addr_q <= 1'b1; wr_q  <= nxt_last; end
        STORE_MEM:   begin addr_q <= 1'b1; ram_q <= nxt_last; end
        EXEC_ALU: begin
          c_q  <= 1'b1;
          wr_q <= 1'b1;
          op_q <= alu_op;
          fl_q <= (decoded_instruction != I_MOVE);
        end
        BRANCH_EVAL: begin branch_q <= taken; pc_q <= taken; end
        NEXT_PC:     pc_q   <= 1'b1;
        HALTED:      halt_q <= 1'b1;
        default:     ;
      endcase
    end
  end

  assign branch           = branch_q & ~rst;
  assign pc_enable        = pc_q & ~rst;
  assign ir_enable        = ir_q & ~rst;
  assign addr_sel         = addr_q & ~rst;
  assign c_sel            = c_q & ~rst;
  assign operation        = op_q & {2{~rst}};
  assign write_reg_enable = wr_q & ~rst;
  assign flags_reg_enable = fl_q & ~rst;
  assign ram_write_enable = ram_q & ~rst;
  assign halt             = halt_q & ~rst;

`ifdef KS_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_retired <= 16'h0000;
      cycle_count   <= 16'h0000;
    end else begin
      if (pc_enable)       instr_retired <= instr_retired + 16'h0001;
      if (state != HALTED) cycle_count   <= cycle_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ks_control_unit.sv
// tb/tb_ks_control_unit.sv - scoreboard bench for ks_control_unit at RAM_WAIT_CYCLES 0 and 2
module tb_ks_control_unit;
  import k_and_s_pkg::*;

  localparam logic [10:0] V_BR = 11'd1, V_PC = 11'd2, V_IR = 11'd4, V_ADDR = 11'd8, V_CSEL = 11'd16;
  localparam logic [10:0] V_WR = 11'd128, V_FL = 11'd256, V_RAM = 11'd512, V_HALT = 11'd1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0 = 1'b1, rst1 = 1'b1;
  decoded_instruction_type ins0 = I_NOP, ins1 = I_NOP;
  logic [3:0] fl0 = 4'h0, fl1 = 4'h0;  // {signed_ov, unsigned_ov, neg, zero}

  logic br0, pc0, ir0, as0, cs0, wr0, fe0, rw0, h0;
  logic br1, pc1, ir1, as1, cs1, wr1, fe1, rw1, h1;
  logic [1:0] op0, op1;
  logic [10:0] act0, act1;
  assign act0 = {h0, rw0, fe0, wr0, op0, cs0, as0, ir0, pc0, br0};
  assign act1 = {h1, rw1, fe1, wr1, op1, cs1, as1, ir1, pc1, br1};

`ifdef KS_CTRL_PERF_CNT_EN
  logic [15:0] ret0, cyc0, ret1, cyc1;
`endif

  ks_control_unit #(.RAM_WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst0), .decoded_instruction(ins0),
    .zero_op(fl0[0]), .neg_op(fl0[1]), .unsigned_overflow(fl0[2]), .signed_overflow(fl0[3]),
    .branch(br0), .pc_enable(pc0), .ir_enable(ir0), .addr_sel(as0), .c_sel(cs0),
    .operation(op0), .write_reg_enable(wr0), .flags_reg_enable(fe0),
    .ram_write_enable(rw0), .halt(h0)
`ifdef KS_CTRL_PERF_CNT_EN
    , .instr_retired(ret0), .cycle_count(cyc0)
`endif
  );

  ks_control_unit #(.RAM_WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst1), .decoded_instruction(ins1),
    .zero_op(fl1[0]), .neg_op(fl1[1]), .unsigned_overflow(fl1[2]), .signed_overflow(fl1[3]),
    .branch(br1), .pc_enable(pc1), .ir_enable(ir1), .addr_sel(as1), .c_sel(cs1),
    .operation(op1), .write_reg_enable(wr1), .flags_reg_enable(fe1),
    .ram_write_enable(rw1), .halt(h1)
`ifdef KS_CTRL_PERF_CNT_EN
    , .instr_retired(ret1), .cycle_count(cyc1)
`endif
  );

  logic [10:0] q0[$];
  logic [10:0] q1[$];
  int checks = 0, passed = 0;
  int cyc_no0 = 0, cyc_no1 = 0;

  task automatic check(input string nm, input int cyc, input logic [10:0] got, input logic [10:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s cycle %0d outputs got=%b expected=%b (halt,ram,flg,wr,op,csel,addr,ir,pc,br)",
                  nm, cyc, got, exp);
  endtask

  // Monitor: one expected output vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q0.size() > 0) begin check("w0", cyc_no0, act0, q0.pop_front()); cyc_no0++; end
    if (q1.size() > 0) begin check("w2", cyc_no1, act1, q1.pop_front()); cyc_no1++; end
  end

  function automatic logic taken_model(input decoded_instruction_type i, input logic [3:0] f);
    case (i)
      I_BRANCH: return 1'b1;
      I_BZERO:  return f[0];
      I_BNZERO: return !f[0];
      I_BNEG:   return f[1];
      I_BNNEG:  return !f[1];
      I_BOV:    return f[2];
      I_BNOV:   return !f[2];
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [10:0] alu_vec(input decoded_instruction_type i);
    int op;
    op = (i == I_AND) ? 1 : (i == I_OR) ? 2 : (i == I_SUB) ? 3 : 0;
    return V_CSEL | V_WR | (11'(op) << 5) | ((i != I_MOVE) ? V_FL : 11'd0);
  endfunction

  // Advance one cycle on DUT d with reset level r, recording what that cycle must show.
  task automatic cyc(input int d, input logic r, input logic [10:0] e);
    @(posedge clk);
    #1;
    if (d == 0) begin rst0 = r; q0.push_back(e); end
    else        begin rst1 = r; q1.push_back(e); end
  endtask

  task automatic run_instr(input int d, input int w, input decoded_instruction_type i,
                           input logic [3:0] f, input bit rst_mid);
    for (int k = 0; k <= w; k++) begin
      cyc(d, 1'b0, (k == w) ? V_IR : 11'd0);
      if (k == 0) begin
        if (d == 0) begin ins0 = i; fl0 = f; end
        else        begin ins1 = i; fl1 = f; end
      end
    end
    cyc(d, 1'b0, 11'd0);
    case (i)
      I_NOP: cyc(d, 1'b0, V_PC);
      I_HALT: begin
        repeat (20) cyc(d, 1'b0, V_HALT);
        cyc(d, 1'b1, 11'd0);
      end
      I_LOAD: begin
        for (int k = 0; k <= w; k++) cyc(d, 1'b0, V_ADDR | ((k == w) ? V_WR : 11'd0));
        cyc(d, 1'b0, V_PC);
      end
      I_STORE: begin
        for (int k = 0; k <= w; k++) begin
          if (rst_mid && k == 1) begin
            cyc(d, 1'b1, 11'd0);
            return;
          end
          cyc(d, 1'b0, V_ADDR | ((k == w) ? V_RAM : 11'd0));
        end
        cyc(d, 1'b0, V_PC);
      end
      I_MOVE, I_ADD, I_SUB, I_AND, I_OR: begin
        cyc(d, 1'b0, alu_vec(i));
        cyc(d, 1'b0, V_PC);
      end
      default: begin
        if (taken_model(i, f)) cyc(d, 1'b0, V_BR | V_PC);
        else begin
          cyc(d, 1'b0, 11'd0);
          cyc(d, 1'b0, V_PC);
        end
      end
    endcase
  endtask

  task automatic stream(input int d, input int w, input int n);
    decoded_instruction_type i;
    cyc(d, 1'b1, 11'd0);
    cyc(d, 1'b1, 11'd0);
    run_instr(d, w, I_ADD, 4'h0, 1'b0);
    run_instr(d, w, I_BZERO, 4'h1, 1'b0);
    run_instr(d, w, I_BZERO, 4'h0, 1'b0);
    run_instr(d, w, I_LOAD, 4'h0, 1'b0);
    run_instr(d, w, I_MOVE, 4'hF, 1'b0);
    run_instr(d, w, I_STORE, 4'h0, (w >= 2));
    run_instr(d, w, I_HALT, 4'h0, 1'b0);
    for (int k = 0; k < n; k++) begin
      i = decoded_instruction_type'($urandom_range(0, 15));
      run_instr(d, w, i, 4'($urandom_range(0, 15)), (i == I_STORE) && (w >= 2) && ($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    fork
      stream(0, 0, 80);
      stream(1, 2, 80);
    join
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() + q1.size() == 0) passed++;
    else $display("FAIL drain leftover expected entries got=%0d required=0", q0.size() + q1.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
